// File: rtl/scene_pkg.sv
// rtl/scene_pkg.sv - shared types and constants for the day/night scene sequencer
//
// Purpose: phase encoding, sky brightness limit and twinkle LFSR definition used by
//          scene_sequencer and its frame tick generator.
// Contents:
//   phase_e     2-bit scene phase (DAY, DUSK, NIGHT, DAWN)
//   SKY_MAX     brightest sky level
//   LFSR_SEED   twinkle LFSR reset value
//   LFSR_TAPS   feedback taps for x^8+x^6+x^5+x^4+1 (left-shifting Fibonacci form)
//   lfsr_next   one LFSR advance
package scene_pkg;

  typedef enum logic [1:0] {
    PH_DAY   = 2'd0,
    PH_DUSK  = 2'd1,
    PH_NIGHT = 2'd2,
    PH_DAWN  = 2'd3
  } phase_e;

  localparam logic [3:0] SKY_MAX   = 4'hF;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Polynomial terms x^8, x^6, x^5, x^4 map to state bits 7, 5, 4, 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - vsync edge detector, pause gate and animation step divider
//
// Purpose: turns the vsync level into a one-cycle frame tick at the start of vertical
//          sync, gates it with pause and divides accepted ticks by STEP_DIV.
// Ports:
//   clk, rst   pixel clock, asynchronous active-high reset
//   vsync      raw vsync level (same clock domain)
//   pause      level; suppresses acc_tick and step
//   div_clr    restart the divider (pending skip being applied)
//   tick       vsync active edge seen this cycle
//   acc_tick   tick while not paused
//   step       accepted tick that completes a STEP_DIV group
module frame_tick_gen #(
  parameter int STEP_DIV      = 1,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic pause,
  input  logic div_clr,
  output logic tick,
  output logic acc_tick,
  output logic step
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(STEP_DIV - 1);
  // Reset the delayed copy to the idle level so leaving reset never fakes an edge.
  localparam logic VS_IDLE = VS_ACTIVE_LOW;

  logic          vs_q;
  logic          vs_d;
  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;

  assign tick     = (vsync != VS_IDLE) && (vs_q == VS_IDLE);
  assign acc_tick = tick && !pause;
  assign step     = acc_tick && (div_cnt_q == DIV_LAST);

  always_comb begin
    vs_d      = vsync;
    div_cnt_d = div_cnt_q;
    if (div_clr || step) begin
      div_cnt_d = '0;
    end else if (acc_tick) begin
      div_cnt_d = div_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q      <= VS_IDLE;
      div_cnt_q <= '0;
    end else begin
      vs_q      <= vs_d;
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - frame-synchronous day/night scene controller
//
// Purpose: sequences DAY -> DUSK -> NIGHT -> DAWN once per animation step and drives
//          sun/moon positions, night flag, sky brightness and star enables. All state
//          changes happen on the cycle after the vsync active edge.
// Ports:
//   clk, rst     25 MHz pixel clock, asynchronous active-high reset
//   vsync        raw vsync level
//   pause        level; freezes animation (a pending skip still applies)
//   skip         1-cycle pulse; jump to the next phase on the next frame tick
//   sun_pos      sun centre x (0..X_MAX)
//   moon_pos     moon centre x (X_MAX..0)
//   moon_active  1 in NIGHT
//   phase        current phase (scene_pkg::phase_e encoding)
//   sky_level    0 full night .. 15 full day
//   star_mask    per-star enables
// Configuration: SCENE_TWINKLE_EN enables the LFSR-driven star twinkle; otherwise all
//                six stars are lit.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int X_MAX         = 639,
  parameter int STEP_DIV      = 1,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       pause,
  input  logic       skip,
  output logic [9:0] sun_pos,
  output logic [9:0] moon_pos,
  output logic       moon_active,
  output logic [1:0] phase,
  output logic [3:0] sky_level,
  output logic [5:0] star_mask
);

  localparam logic [9:0] X_LAST = 10'(X_MAX);

  logic tick;
  logic acc_tick;
  logic step;
  logic skip_apply;

  phase_e     phase_q, phase_d;
  logic [9:0] sun_pos_q, sun_pos_d;
  logic [9:0] moon_pos_q, moon_pos_d;
  logic [3:0] sky_level_q, sky_level_d;
  logic       moon_active_q, moon_active_d;
  logic       skip_pend_q, skip_pend_d;

  // A pending skip is consumed by any tick, paused or not.
  assign skip_apply = tick && skip_pend_q;

  frame_tick_gen #(
    .STEP_DIV      (STEP_DIV),
    .VS_ACTIVE_LOW (VS_ACTIVE_LOW)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .vsync    (vsync),
    .pause    (pause),
    .div_clr  (skip_apply),
    .tick     (tick),
    .acc_tick (acc_tick),
    .step     (step)
  );

  always_comb begin
    phase_d     = phase_q;
    sun_pos_d   = sun_pos_q;
    moon_pos_d  = moon_pos_q;
    sky_level_d = sky_level_q;
    // A skip landing on a tick cycle is kept for the following tick.
    skip_pend_d = skip || (skip_pend_q && !tick);

    if (skip_apply) begin
      // Forced jump: load the entry values of the next phase, ignoring any step.
      case (phase_q)
        PH_DAY: begin
          phase_d     = PH_DUSK;
          sky_level_d = SKY_MAX;
          sun_pos_d   = '0;
        end
        PH_DUSK: begin
          phase_d     = PH_NIGHT;
          sky_level_d = '0;
          moon_pos_d  = X_LAST;
        end
        PH_NIGHT: begin
          phase_d     = PH_DAWN;
          sky_level_d = '0;
          moon_pos_d  = X_LAST;
        end
        PH_DAWN: begin
          phase_d     = PH_DAY;
          sky_level_d = SKY_MAX;
          sun_pos_d   = '0;
        end
        default: ;
      endcase
    end else if (step) begin
      case (phase_q)
        PH_DAY: begin
          if (sun_pos_q < X_LAST) begin
            sun_pos_d = sun_pos_q + 10'd1;
          end else begin
            phase_d   = PH_DUSK;
            sun_pos_d = '0;
          end
        end
        PH_DUSK: begin
          if (sky_level_q > 4'd0) begin
            sky_level_d = sky_level_q - 4'd1;
          end else begin
            phase_d    = PH_NIGHT;
            moon_pos_d = X_LAST;
          end
        end
        PH_NIGHT: begin
          if (moon_pos_q > 10'd0) begin
            moon_pos_d = moon_pos_q - 10'd1;
          end else begin
            phase_d    = PH_DAWN;
            moon_pos_d = X_LAST;
          end
        end
        PH_DAWN: begin
          if (sky_level_q < SKY_MAX) begin
            sky_level_d = sky_level_q + 4'd1;
          end else begin
            phase_d   = PH_DAY;
            sun_pos_d = '0;
          end
        end
        default: ;
      endcase
    end

    moon_active_d = (phase_d == PH_NIGHT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= PH_DAY;
      sun_pos_q     <= '0;
      moon_pos_q    <= X_LAST;
      sky_level_q   <= SKY_MAX;
      moon_active_q <= 1'b0;
      skip_pend_q   <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      sun_pos_q     <= sun_pos_d;
      moon_pos_q    <= moon_pos_d;
      sky_level_q   <= sky_level_d;
      moon_active_q <= moon_active_d;
      skip_pend_q   <= skip_pend_d;
    end
  end

  assign sun_pos     = sun_pos_q;
  assign moon_pos    = moon_pos_q;
  assign moon_active = moon_active_q;
  assign phase       = phase_q;
  assign sky_level   = sky_level_q;

`ifdef SCENE_TWINKLE_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [5:0] star_mask_q, star_mask_d;

  // Star 0 stays lit so the sky never goes completely dark.
  always_comb begin
    lfsr_d      = lfsr_q;
    star_mask_d = star_mask_q;
    if (acc_tick) begin
      lfsr_d      = lfsr_next(lfsr_q);
      star_mask_d = lfsr_q[5:0] | 6'b000001;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q      <= LFSR_SEED;
      star_mask_q <= 6'h3F;
    end else begin
      lfsr_q      <= lfsr_d;
      star_mask_q <= star_mask_d;
    end
  end

  assign star_mask = star_mask_q;
`else
  logic unused_acc_tick;
  assign unused_acc_tick = acc_tick;
  assign star_mask       = 6'h3F;
`endif

endmodule

// File: tb/tb_scene_sequencer.sv
// tb/tb_scene_sequencer.sv - randomized model-checked bench for scene_sequencer
module tb_scene_sequencer;

  localparam int X_MAX = 639;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b1;
  logic pause = 1'b0;
  logic skip = 1'b0;

  logic [9:0] s1_sun, s1_moon, s4_sun, s4_moon;
  logic       s1_ma, s4_ma;
  logic [1:0] s1_ph, s4_ph;
  logic [3:0] s1_sky, s4_sky;
  logic [5:0] s1_star, s4_star;

  always #5 clk = ~clk;

  scene_sequencer #(.X_MAX(X_MAX), .STEP_DIV(1), .VS_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .vsync(vsync), .pause(pause), .skip(skip),
    .sun_pos(s1_sun), .moon_pos(s1_moon), .moon_active(s1_ma), .phase(s1_ph),
    .sky_level(s1_sky), .star_mask(s1_star)
  );

  scene_sequencer #(.X_MAX(X_MAX), .STEP_DIV(4), .VS_ACTIVE_LOW(1'b1)) dut4 (
    .clk(clk), .rst(rst), .vsync(vsync), .pause(pause), .skip(skip),
    .sun_pos(s4_sun), .moon_pos(s4_moon), .moon_active(s4_ma), .phase(s4_ph),
    .sky_level(s4_sky), .star_mask(s4_star)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural scene model (index 0: STEP_DIV=1, 1: STEP_DIV=4) --------
  int m_div[2] = '{1, 4};
  int m_ph[2], m_sun[2], m_moon[2], m_sky[2], m_cnt[2];
  bit m_pend[2];
  bit vs_prev;
  int m_lfsr;
  int m_star;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_sun[i] = 0; m_moon[i] = X_MAX; m_sky[i] = 15;
      m_cnt[i] = 0; m_pend[i] = 0;
    end
    vs_prev = 1'b1;
    m_lfsr = 8'hA5;
    m_star = 6'h3F;
  endtask

  // Phase rules: DAY sun 0..X_MAX, DUSK sky 15..0, NIGHT moon X_MAX..0, DAWN sky 0..15.
  task automatic model_step(input int i);
    case (m_ph[i])
      0: if (m_sun[i] < X_MAX) m_sun[i]++; else begin m_ph[i] = 1; m_sun[i] = 0; end
      1: if (m_sky[i] > 0) m_sky[i]--; else begin m_ph[i] = 2; m_moon[i] = X_MAX; end
      2: if (m_moon[i] > 0) m_moon[i]--; else begin m_ph[i] = 3; m_moon[i] = X_MAX; end
      default: if (m_sky[i] < 15) m_sky[i]++; else begin m_ph[i] = 0; m_sun[i] = 0; end
    endcase
  endtask

  task automatic model_skip(input int i);
    m_ph[i] = (m_ph[i] + 1) % 4;
    case (m_ph[i])
      1: begin m_sky[i] = 15; m_sun[i] = 0; end
      2: begin m_sky[i] = 0; m_moon[i] = X_MAX; end
      3: begin m_sky[i] = 0; m_moon[i] = X_MAX; end
      default: begin m_sky[i] = 15; m_sun[i] = 0; end
    endcase
    m_cnt[i] = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      bit t;
      t = vs_prev && !vsync;
      vs_prev = vsync;
      for (int i = 0; i < 2; i++) begin
        if (t && m_pend[i]) begin
          model_skip(i);
          m_pend[i] = skip;
        end else begin
          if (t && !pause) begin
            m_cnt[i]++;
            if (m_cnt[i] == m_div[i]) begin
              m_cnt[i] = 0;
              model_step(i);
            end
          end
          m_pend[i] = m_pend[i] || skip;
        end
      end
      if (t && !pause) begin
        bit [7:0] l;
        l = 8'(m_lfsr);
        m_star = int'(l[5:0]) | 1;
        m_lfsr = int'({l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]});
      end
    end
  end

  function automatic int exp_star();
`ifdef SCENE_TWINKLE_EN
    return m_star;
`else
    return 6'h3F;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("sun1", int'(s1_sun), m_sun[0]);
      check("moon1", int'(s1_moon), m_moon[0]);
      check("phase1", int'(s1_ph), m_ph[0]);
      check("sky1", int'(s1_sky), m_sky[0]);
      check("moon_act1", int'(s1_ma), int'(m_ph[0] == 2));
      check("star1", int'(s1_star), exp_star());
      check("sun4", int'(s4_sun), m_sun[1]);
      check("moon4", int'(s4_moon), m_moon[1]);
      check("phase4", int'(s4_ph), m_ph[1]);
      check("sky4", int'(s4_sky), m_sky[1]);
      check("moon_act4", int'(s4_ma), int'(m_ph[1] == 2));
      check("star4", int'(s4_star), exp_star());
      check("star0_lit", int'(s1_star[0]), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // One frame: vsync low for 2 cycles then high; optional skip pulse at cycle skip_at.
  task automatic frame(input int len, input int skip_at);
    for (int c = 0; c < len; c++) begin
      vsync = (c < 2) ? 1'b0 : 1'b1;
      skip  = (c == skip_at);
      @(posedge clk); #2;
    end
    skip = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) frame(6, -1);
  endtask

  task automatic pulse_skip();
    skip = 1'b1; cyc(1); skip = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sun1"}, int'(s1_sun), 0);
    check({tag, "_moon1"}, int'(s1_moon), X_MAX);
    check({tag, "_phase1"}, int'(s1_ph), 0);
    check({tag, "_sky1"}, int'(s1_sky), 15);
    check({tag, "_ma1"}, int'(s1_ma), 0);
    check({tag, "_star1"}, int'(s1_star), 6'h3F);
    check({tag, "_sun4"}, int'(s4_sun), 0);
    check({tag, "_phase4"}, int'(s4_ph), 0);
    check({tag, "_sky4"}, int'(s4_sky), 15);
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check_reset_vals("reset");
    chk_en = 1'b1;

    // Full day: 639 steps to the right edge, the 640th enters DUSK.
    frames(639);
    check("day_end_sun", int'(s1_sun), 639);
    check("day_end_phase", int'(s1_ph), 0);
    frames(1);
    check("dusk_phase", int'(s1_ph), 1);
    check("dusk_sun", int'(s1_sun), 0);
    check("dusk_sky", int'(s1_sky), 15);
    check("div4_sun", int'(s4_sun), 160);
`ifdef SCENE_TWINKLE_EN
    check("twinkle_first", int'(s1_star), exp_star());
`endif

    frames(15);
    check("dusk_dark", int'(s1_sky), 0);
    frames(1);
    check("night_phase", int'(s1_ph), 2);
    check("night_ma", int'(s1_ma), 1);
    check("night_moon", int'(s1_moon), 639);
    frames(639);
    check("night_moon0", int'(s1_moon), 0);
    frames(1);
    check("dawn_phase", int'(s1_ph), 3);
    frames(16);
    check("day_again", int'(s1_ph), 0);
    check("day_again_sky", int'(s1_sky), 15);

    // Pause freezes, release resumes.
    frames(100);
    check("pre_pause_sun", int'(s1_sun), 100);
    pause = 1'b1;
    frames(10);
    check("paused_sun", int'(s1_sun), 100);
    pause = 1'b0;
    frames(1);
    check("resume_sun", int'(s1_sun), 101);

    // Mid-frame skip waits for the vsync edge.
    frames(199);
    check("pre_skip_sun", int'(s1_sun), 300);
    pulse_skip();
    cyc(2);
    check("skip_wait_sun", int'(s1_sun), 300);
    check("skip_wait_phase", int'(s1_ph), 0);
    frames(1);
    check("skip_phase", int'(s1_ph), 1);
    check("skip_sun", int'(s1_sun), 0);
    check("skip_sky", int'(s1_sky), 15);
    check("skip4_phase", int'(s4_ph), 1);

    // Divider restarted by the skip: 4 frames for the first step.
    frames(3);
    check("div4_hold", int'(s4_sky), 15);
    frames(1);
    check("div4_step", int'(s4_sky), 14);

    // Skip while paused still applies.
    pause = 1'b1;
    pulse_skip();
    frames(1);
    check("pskip_phase", int'(s1_ph), 2);
    check("pskip_moon", int'(s1_moon), 639);
    check("pskip_sky", int'(s1_sky), 0);
    check("pskip_ma", int'(s1_ma), 1);
    pause = 1'b0;

    // Randomized frames, pauses and skips (including skips on the tick cycle).
    for (int f = 0; f < 1500; f++) begin
      int len, sa;
      len = $urandom_range(3, 8);
      sa = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      pause = ($urandom_range(0, 9) == 0);
      frame(len, sa);
    end
    pause = 1'b0;

    // Reach NIGHT, then reset asynchronously between clock edges.
    for (int k = 0; k < 5; k++) begin
      if (s1_ph == 2'd2) break;
      pulse_skip();
      frame(5, -1);
    end
    check("reach_night", int'(s1_ph), 2);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    cyc(2);
    rst = 1'b0;
    cyc(1);
    frame(5, -1);
    check("post_rst_sun", int'(s1_sun), 1);
`ifdef SCENE_TWINKLE_EN
    check("post_rst_star", int'(s1_star), 6'h25);
`endif
    frames(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
